// File: rtl/dreg_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : dreg_arbiter
// Description : Round-robin arbiter; grants one requester, bit-reverses its
//               data into a shared result register held until consumed.
// Revision    : 1.0 - initial release
// ============================================================================
module dreg_arbiter #(
  parameter int N = 2,
  parameter int R = 4,
  localparam int IW = (R > 1) ? $clog2(R) : 1
) (
  input  logic           clock,
  input  logic           rstn,
  input  logic [R-1:0]   req,
  input  logic [R*N-1:0] req_data,
  output logic [R-1:0]   gnt,
  output logic           out_valid,
  output logic [N-1:0]   out_data,
  output logic [IW-1:0]  out_id,
  input  logic           out_ready,
  output logic           busy
);

  localparam logic [1:0] c_idle  = 2'd0;
  localparam logic [1:0] c_load  = 2'd1;
  localparam logic [1:0] c_valid = 2'd2;

  localparam logic [IW-1:0] c_last = IW'(R - 1);

  logic [1:0]    r_state;
  logic [IW-1:0] r_ptr;
  logic [R-1:0]  r_gnt;
  logic [N-1:0]  r_cap_data;
  logic [IW-1:0] r_cap_id;
  logic [N-1:0]  r_out_data;
  logic [IW-1:0] r_out_id;

  logic          w_any;
  logic [IW-1:0] w_sel;
  logic [R-1:0]  w_onehot;
  logic [N-1:0]  w_word;
  logic [N-1:0]  w_rev;
  logic [IW-1:0] w_next_ptr;
  int            w_idx;

  // Walk offsets from farthest to nearest so the nearest set bit past ptr wins.
  always_comb begin
    w_any    = 1'b0;
    w_sel    = '0;
    w_idx    = 0;
    w_onehot = '0;
    for (int off = R - 1; off >= 0; off--) begin
      w_idx = (int'(r_ptr) + off) % R;
      if (req[w_idx]) begin
        w_any = 1'b1;
        w_sel = IW'(w_idx);
      end
    end
    w_onehot[w_sel] = w_any;
  end

  assign w_word = req_data[int'(w_sel)*N +: N];

  for (genvar i = 0; i < N; i++) begin : g_rev
    assign w_rev[i] = w_word[N-1-i];
  end

  assign w_next_ptr = (r_out_id == c_last) ? '0 : r_out_id + 1'b1;

  // Captured data stays private until LOAD so the visible result only changes on entering VALID.
  always_ff @(posedge clock or negedge rstn) begin
    if (!rstn) begin
      r_state    <= c_idle;
      r_ptr      <= '0;
      r_gnt      <= '0;
      r_cap_data <= '0;
      r_cap_id   <= '0;
      r_out_data <= '0;
      r_out_id   <= '0;
    end else begin
      case (r_state)
        c_idle: begin
          if (w_any) begin
            r_gnt      <= w_onehot;
            r_cap_data <= w_rev;
            r_cap_id   <= w_sel;
            r_state    <= c_load;
          end
        end
        c_load: begin
          r_gnt      <= '0;
          r_out_data <= r_cap_data;
          r_out_id   <= r_cap_id;
          r_state    <= c_valid;
        end
        c_valid: begin
          if (out_ready) begin
            r_ptr   <= w_next_ptr;
            r_state <= c_idle;
          end
        end
        default: begin
          r_gnt   <= '0;
          r_state <= c_idle;
        end
      endcase
    end
  end

  assign gnt       = r_gnt;
  assign out_valid = (r_state == c_valid);
  assign out_data  = r_out_data;
  assign out_id    = r_out_id;
  assign busy      = (r_state != c_idle);

endmodule
`default_nettype wire
